// File: rtl/minterm_sweep_ctrl.sv
// rtl/minterm_sweep_ctrl.sv - sweeps every select code of a function unit and checks its truth table
module minterm_sweep_ctrl #(
    parameter int N_IN       = 4,
    parameter int SAMPLE_LAT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [(1<<N_IN)-1:0] expected,
    input  logic                 f_in,
    output logic [N_IN-1:0]      sel_out,
    output logic                 sel_valid,
    output logic                 busy,
    output logic                 done,
    output logic [(1<<N_IN)-1:0] truth_table,
    output logic [N_IN:0]        ones_cnt,
    output logic                 match,
    output logic [N_IN-1:0]      mismatch_idx
);
    localparam int WW = (SAMPLE_LAT > 0) ? $clog2(SAMPLE_LAT + 1) : 1;
    localparam logic [WW-1:0]   LAST_WAIT = WW'(SAMPLE_LAT);
    localparam logic [N_IN-1:0] LAST_IDX  = {N_IN{1'b1}};

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t                 state_q, state_d;
    logic [N_IN-1:0]        idx_q;
    logic [WW-1:0]          wait_q;
    logic [(1<<N_IN)-1:0]   exp_q;
    logic                   mm_flag;
    logic                   accept;
    logic                   sample;
    logic                   differs;

    assign accept  = (state_q == IDLE) && start && !abort;
    assign sample  = (state_q == RUN) && !abort && (wait_q == LAST_WAIT);
    assign differs = (f_in != exp_q[idx_q]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_out   = '0;
        sel_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) state_d = RUN;
            end
            RUN: begin
                sel_out   = idx_q;
                sel_valid = 1'b1;
                busy      = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else if (wait_q == LAST_WAIT && idx_q == LAST_IDX) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // match is resolved on the final sample edge so it is already valid while done is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            wait_q       <= '0;
            exp_q        <= '0;
            mm_flag      <= 1'b0;
            truth_table  <= '0;
            ones_cnt     <= '0;
            match        <= 1'b0;
            mismatch_idx <= '0;
        end else if (accept) begin
            idx_q        <= '0;
            wait_q       <= '0;
            exp_q        <= expected;
            mm_flag      <= 1'b0;
            truth_table  <= '0;
            ones_cnt     <= '0;
            match        <= 1'b0;
            mismatch_idx <= '0;
        end else if (sample) begin
            wait_q             <= '0;
            truth_table[idx_q] <= f_in;
            ones_cnt           <= ones_cnt + {{N_IN{1'b0}}, f_in};
            if (differs && !mm_flag) begin
                mismatch_idx <= idx_q;
                mm_flag      <= 1'b1;
            end
            if (idx_q == LAST_IDX) begin
                match <= !(mm_flag || differs);
                if (!(mm_flag || differs)) mismatch_idx <= '0;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end else if (state_q == RUN && !abort) begin
            wait_q <= wait_q + 1'b1;
        end else if (state_q != IDLE) begin
            idx_q  <= '0;
            wait_q <= '0;
        end
    end
endmodule

// File: tb/tb_minterm_sweep_ctrl.sv
// tb/tb_minterm_sweep_ctrl.sv - self-checking bench for minterm_sweep_ctrl at SAMPLE_LAT 0 and 1
module tb_minterm_sweep_ctrl;
    localparam logic [15:0] FUNC = 16'h9CFC;

    logic        clk = 1'b0;
    logic [1:0]  rst_v = 2'b00;
    logic [1:0]  start_v = 2'b00;
    logic [1:0]  abort_v = 2'b00;
    logic [15:0] exp_a[2];
    logic [15:0] fmask_a[2];
    logic        f0;
    logic        f1_q = 1'b0;

    logic [3:0]  sel_o[2];
    logic        sel_v[2];
    logic        busy_o[2];
    logic        done_o[2];
    logic [15:0] tab_o[2];
    logic [4:0]  ones_o[2];
    logic        match_o[2];
    logic [3:0]  mmi_o[2];

    int checks = 0;
    int errors = 0;

    int          m_t[2];
    bit          m_fin[2];
    int          m_ns[2];
    logic [15:0] m_exp[2];
    logic [15:0] m_fm[2];
    bit          m_match[2];

    always #5 clk = ~clk;

    assign f0 = fmask_a[0][sel_o[0]];
    always @(posedge clk) f1_q <= fmask_a[1][sel_o[1]];

    minterm_sweep_ctrl #(.N_IN(4), .SAMPLE_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_v[0]), .start(start_v[0]), .abort(abort_v[0]),
        .expected(exp_a[0]), .f_in(f0), .sel_out(sel_o[0]), .sel_valid(sel_v[0]),
        .busy(busy_o[0]), .done(done_o[0]), .truth_table(tab_o[0]), .ones_cnt(ones_o[0]),
        .match(match_o[0]), .mismatch_idx(mmi_o[0])
    );

    minterm_sweep_ctrl #(.N_IN(4), .SAMPLE_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_v[1]), .start(start_v[1]), .abort(abort_v[1]),
        .expected(exp_a[1]), .f_in(f1_q), .sel_out(sel_o[1]), .sel_valid(sel_v[1]),
        .busy(busy_o[1]), .done(done_o[1]), .truth_table(tab_o[1]), .ones_cnt(ones_o[1]),
        .match(match_o[1]), .mismatch_idx(mmi_o[1])
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [15:0] lowmask(input int n);
        logic [31:0] m;
        m = (32'h1 << n) - 32'h1;
        return m[15:0];
    endfunction

    function automatic int lowest_bit(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset(input int d);
        m_t[d] = -1; m_fin[d] = 0; m_ns[d] = 0;
        m_exp[d] = '0; m_fm[d] = '0; m_match[d] = 0;
    endtask

    // Sweep time m_t counts RUN cycles; codes sampled so far is m_t/(lat+1)
    task automatic model_step(input int d);
        int per;
        per = d + 1;
        if (!rst_v[d]) begin
            model_reset(d);
        end else if (m_fin[d]) begin
            m_fin[d] = 0;
        end else if (m_t[d] >= 0) begin
            if (abort_v[d]) begin
                m_t[d] = -1;
            end else begin
                m_t[d]++;
                if (m_t[d] % per == 0) m_ns[d] = m_t[d] / per;
                if (m_t[d] == 16 * per) begin
                    m_t[d] = -1;
                    m_fin[d] = 1;
                    m_match[d] = (m_fm[d] == m_exp[d]);
                end
            end
        end else if (start_v[d] && !abort_v[d]) begin
            m_t[d] = 0; m_ns[d] = 0; m_match[d] = 0;
            m_exp[d] = exp_a[d]; m_fm[d] = fmask_a[d];
        end
    endtask

    task automatic compare(input int d);
        logic [15:0] tab;
        logic [15:0] diff;
        bit          run;
        run  = (m_t[d] >= 0);
        tab  = m_fm[d] & lowmask(m_ns[d]);
        diff = (tab ^ m_exp[d]) & lowmask(m_ns[d]);
        chk($sformatf("d%0d sel_out", d), 32'(sel_o[d]), run ? 32'(m_t[d] / (d + 1)) : 32'd0);
        chk($sformatf("d%0d sel_valid", d), 32'(sel_v[d]), 32'(run));
        chk($sformatf("d%0d busy", d), 32'(busy_o[d]), 32'(run));
        chk($sformatf("d%0d done", d), 32'(done_o[d]), 32'(m_fin[d]));
        chk($sformatf("d%0d table", d), 32'(tab_o[d]), 32'(tab));
        chk($sformatf("d%0d ones_cnt", d), 32'(ones_o[d]), 32'($countones(tab)));
        chk($sformatf("d%0d match", d), 32'(match_o[d]), 32'(m_match[d]));
        chk($sformatf("d%0d mismatch_idx", d), 32'(mmi_o[d]),
            m_match[d] ? 32'd0 : 32'(lowest_bit(diff)));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        compare(0);
        compare(1);
    endtask

    task automatic run(input int d, input int n, input int start_cycles,
                       output int dones, output int first_done);
        dones = 0;
        first_done = -1;
        start_v[d] = (start_cycles > 0);
        for (int c = 1; c <= n; c++) begin
            tick();
            if (c >= start_cycles) start_v[d] = 1'b0;
            if (done_o[d]) begin
                dones++;
                if (first_done < 0) first_done = c;
            end
        end
    endtask

    task automatic wait_sel(input int d, input logic [3:0] code);
        bit found;
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (sel_v[d] && sel_o[d] == code) found = 1;
            else tick();
        end
        chk($sformatf("d%0d reached sel %0d", d, code), 32'(found), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int dn, fd, nb;
        exp_a[0] = '0; exp_a[1] = '0;
        fmask_a[0] = FUNC; fmask_a[1] = FUNC;
        model_reset(0); model_reset(1);
        tick(); tick();
        rst_v = 2'b11;
        tick();
        chk("reset busy", 32'(busy_o[0]), 32'd0);
        chk("reset table", 32'(tab_o[0]), 32'd0);

        exp_a[0] = 16'h9CFC;
        run(0, 20, 1, dn, fd);
        chk("t1 dones", dn, 1);
        chk("t1 done latency", fd, 17);
        chk("t1 table", 32'(tab_o[0]), 32'h9CFC);
        chk("t1 ones", 32'(ones_o[0]), 32'd10);
        chk("t1 match", 32'(match_o[0]), 32'd1);
        chk("t1 mismatch_idx", 32'(mmi_o[0]), 32'd0);

        exp_a[0] = 16'h9CF8;
        run(0, 20, 1, dn, fd);
        chk("t2 table", 32'(tab_o[0]), 32'h9CFC);
        chk("t2 match", 32'(match_o[0]), 32'd0);
        chk("t2 mismatch_idx", 32'(mmi_o[0]), 32'd2);
        exp_a[0] = 16'h1CFC;
        run(0, 20, 1, dn, fd);
        chk("t2b mismatch_idx", 32'(mmi_o[0]), 32'd15);

        exp_a[1] = 16'h9CFC;
        run(1, 36, 1, dn, fd);
        chk("t3 dones", dn, 1);
        chk("t3 done latency", fd, 33);
        chk("t3 match", 32'(match_o[1]), 32'd1);
        chk("t3 table", 32'(tab_o[1]), 32'h9CFC);

        exp_a[0] = 16'h9CFC;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        wait_sel(0, 4'd7);
        abort_v[0] = 1'b1;
        tick();
        abort_v[0] = 1'b0;
        chk("t4 busy after abort", 32'(busy_o[0]), 32'd0);
        run(0, 20, 0, dn, fd);
        chk("t4 dones", dn, 0);
        chk("t4 table", 32'(tab_o[0]), 32'h007C);
        chk("t4 ones", 32'(ones_o[0]), 32'd5);
        chk("t4 match", 32'(match_o[0]), 32'd0);
        run(0, 20, 1, dn, fd);
        chk("t4 rerun table", 32'(tab_o[0]), 32'h9CFC);
        chk("t4 rerun match", 32'(match_o[0]), 32'd1);

        run(0, 40, 35, dn, fd);
        chk("t5 held start dones", dn, 2);
        chk("t5 held start first", fd, 17);

        start_v[0] = 1'b1;
        abort_v[0] = 1'b1;
        nb = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            start_v[0] = 1'b0;
            abort_v[0] = 1'b0;
            if (busy_o[0] || done_o[0]) nb++;
        end
        chk("t5 start+abort busy", nb, 0);

        start_v[0] = 1'b1;
        dn = 0;
        for (int c = 1; c <= 24; c++) begin
            tick();
            start_v[0] = (c == 5);
            if (done_o[0]) dn++;
        end
        chk("t5 start during run dones", dn, 1);

        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        wait_sel(0, 4'd9);
        #2;
        rst_v[0] = 1'b0;
        #1;
        model_reset(0);
        chk("t6 sel_out", 32'(sel_o[0]), 32'd0);
        chk("t6 sel_valid", 32'(sel_v[0]), 32'd0);
        chk("t6 busy", 32'(busy_o[0]), 32'd0);
        chk("t6 done", 32'(done_o[0]), 32'd0);
        chk("t6 table", 32'(tab_o[0]), 32'd0);
        chk("t6 ones", 32'(ones_o[0]), 32'd0);
        chk("t6 match", 32'(match_o[0]), 32'd0);
        chk("t6 mismatch_idx", 32'(mmi_o[0]), 32'd0);
        tick();
        tick();
        rst_v[0] = 1'b1;
        fmask_a[0] = 16'hFFFF;
        run(0, 20, 1, dn, fd);
        chk("t6 stuck dones", dn, 1);
        chk("t6 stuck table", 32'(tab_o[0]), 32'hFFFF);
        chk("t6 stuck ones", 32'(ones_o[0]), 32'd16);
        chk("t6 stuck match", 32'(match_o[0]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
